// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and FSM state type for the AES-128 round controller
// Purpose : block/round widths and the controller state enumeration, shared by
//           the controller, its interface and any wrapper that pairs it with a datapath.
// Ports   : none (package).
package aes_pkg;

   localparam int BLOCK_W    = 128;
   localparam int NUM_ROUNDS = 10;
   localparam int ROUND_W    = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - handshake and datapath bundle of the AES-128 round controller
// Purpose : groups the input/output handshakes and the external round-datapath port.
// Signals : in_valid/in_ready/plaintext/key  - block intake handshake
//           out_valid/out_ready/ciphertext   - result handshake
//           abort, busy                      - cancel request and activity flag
//           dp_round/dp_state/dp_key         - controller -> datapath
//           dp_out/dp_key_next               - datapath -> controller (combinational)
// Modports: slave  - the controller side
//           master - the producer/consumer plus datapath side
interface aes_round_ctrl_if import aes_pkg::*; ();

   logic                 in_valid;
   logic                 in_ready;
   logic [0:BLOCK_W-1]   plaintext;
   logic [0:BLOCK_W-1]   key;
   logic                 abort;
   logic                 out_valid;
   logic                 out_ready;
   logic [0:BLOCK_W-1]   ciphertext;
   logic                 busy;
   logic [0:ROUND_W-1]   dp_round;
   logic [0:BLOCK_W-1]   dp_state;
   logic [0:BLOCK_W-1]   dp_key;
   logic [0:BLOCK_W-1]   dp_out;
   logic [0:BLOCK_W-1]   dp_key_next;

   modport slave (
      input  in_valid, plaintext, key, abort, out_ready, dp_out, dp_key_next,
      output in_ready, out_valid, ciphertext, busy, dp_round, dp_state, dp_key
   );

   modport master (
      output in_valid, plaintext, key, abort, out_ready, dp_out, dp_key_next,
      input  in_ready, out_valid, ciphertext, busy, dp_round, dp_state, dp_key
   );

endinterface

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 iterative round sequencer driving an external round datapath
// Purpose : accepts a plaintext/key pair, steps an external round datapath through
//           rounds 0..10 (one round per cycle), holds the result until consumed.
// Ports   : clk   - sole clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - aes_round_ctrl_if.slave (handshakes, abort, busy, datapath port)
module aes_round_ctrl import aes_pkg::*; (
   input  logic             clk,
   input  logic             rst_n,
   aes_round_ctrl_if.slave  bus
);

   localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NUM_ROUNDS);

   aes_state_e           st_q;
   logic [ROUND_W-1:0]   rnd_q;
   logic [0:BLOCK_W-1]   state_q;
   logic [0:BLOCK_W-1]   key_q;
   // Low through reset and for the first edge after it, so in_ready stays low
   // while rst_n is asserted even though the FSM already sits in IDLE.
   logic                 alive_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= ST_IDLE;
         rnd_q   <= '0;
         state_q <= '0;
         key_q   <= '0;
         alive_q <= 1'b0;
      end else begin
         alive_q <= 1'b1;
         case (st_q)
            ST_IDLE: begin
               // abort is deliberately not looked at here
               if (bus.in_valid && alive_q) begin
                  st_q    <= ST_RUN;
                  state_q <= bus.plaintext;
                  key_q   <= bus.key;
                  rnd_q   <= '0;
               end
            end
            ST_RUN: begin
               if (bus.abort) begin
                  st_q  <= ST_IDLE;
                  rnd_q <= '0;
               end else begin
                  state_q <= bus.dp_out;
                  // round 0 is the plain AddRoundKey with the cipher key itself,
                  // so the schedule only advances from round 1 onwards
                  if (rnd_q != '0) begin
                     key_q <= bus.dp_key_next;
                  end
                  if (rnd_q == LAST_RND) begin
                     st_q  <= ST_DONE;
                     rnd_q <= '0;
                  end else begin
                     rnd_q <= rnd_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (bus.abort || bus.out_ready) begin
                  st_q <= ST_IDLE;
               end
            end
            default: begin
               st_q  <= ST_IDLE;
               rnd_q <= '0;
            end
         endcase
      end
   end

   wire run  = (st_q == ST_RUN);
   wire done = (st_q == ST_DONE);

   assign bus.in_ready   = alive_q && (st_q == ST_IDLE);
   assign bus.busy       = (st_q != ST_IDLE);
   assign bus.out_valid  = done;
   assign bus.ciphertext = done ? state_q : '0;
   assign bus.dp_round   = run ? rnd_q : '0;
   assign bus.dp_state   = run ? state_q : '0;
   assign bus.dp_key     = run ? key_q : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl with a behavioural AES round datapath
module tb_aes_round_ctrl;

   localparam logic [0:127] C1_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [0:127] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic ov_prev = 1'b0;

   typedef struct { logic [0:127] ct; int acc; } exp_t;
   exp_t sb[$];

   logic [7:0] sbox [256];

   aes_round_ctrl_if bus ();

   aes_round_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural AES datapath ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sb_calc(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [0:127] kexp(input logic [0:127] k, input int r);
      logic [0:127] o;
      logic [0:31]  t;
      logic [7:0]   rc;
      if (r < 1 || r > 10) return k;
      rc = 8'h01;
      for (int i = 1; i < r; i++) rc = xt(rc);
      t = {sbox[k[104 +: 8]], sbox[k[112 +: 8]], sbox[k[120 +: 8]], sbox[k[96 +: 8]]};
      t[0:7] = t[0:7] ^ rc;
      o[0:31]   = k[0:31]   ^ t;
      o[32:63]  = k[32:63]  ^ o[0:31];
      o[64:95]  = k[64:95]  ^ o[32:63];
      o[96:127] = k[96:127] ^ o[64:95];
      return o;
   endfunction

   function automatic logic [0:127] aes_rnd(input logic [0:127] st, input logic [0:127] rk, input int r);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [0:127] o;
      if (r == 0) return st ^ rk;
      for (int i = 0; i < 16; i++) b[i] = sbox[st[8*i +: 8]];
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++) t[4*c+w] = b[((c+w)%4)*4+w];
      b = t;
      if (r != 10) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
         end
      end
      for (int i = 0; i < 16; i++) o[8*i +: 8] = b[i] ^ rk[8*i +: 8];
      return o;
   endfunction

   always_comb begin
      bus.dp_key_next = kexp(bus.dp_key, int'(bus.dp_round));
      bus.dp_out      = aes_rnd(bus.dp_state, bus.dp_key_next, int'(bus.dp_round));
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", nm, act, req);
      end
   endtask

   task automatic chki(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // ---------------- monitor: compare on rise, retire on fall ----------------
   always @(negedge clk) begin
      if (bus.out_valid && !ov_prev) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid actual=%h required=none", bus.ciphertext);
         end else begin
            chk("ciphertext", bus.ciphertext, sb[0].ct);
            chki("latency", cyc - sb[0].acc, 11);
         end
      end
      if (!bus.out_valid && ov_prev && sb.size() > 0) void'(sb.pop_front());
      ov_prev <= bus.out_valid;
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [0:127] pt, input logic [0:127] k, input logic [0:127] exp_ct,
                        input bit push, input bit ab);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
      chkb("issue_in_ready", bus.in_ready, 1'b1);
      bus.in_valid  = 1'b1;
      bus.plaintext = pt;
      bus.key       = k;
      bus.abort     = ab;
      @(posedge clk); #1;
      if (push) begin
         e.ct  = exp_ct;
         e.acc = cyc;
         sb.push_back(e);
      end
      bus.in_valid  = 1'b0;
      bus.abort     = 1'b0;
      bus.plaintext = '0;
      bus.key       = '0;
   endtask

   task automatic wait_round(input int r);
      int n;
      n = 0;
      @(negedge clk);
      while (int'(bus.dp_round) != r && n < 30) begin @(negedge clk); n++; end
      chki("reach_round", int'(bus.dp_round), r);
   endtask

   task automatic wait_ov();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 30) begin @(negedge clk); n++; end
      chkb("reach_out_valid", bus.out_valid, 1'b1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 60) begin @(negedge clk); n++; end
      chkb("reach_idle", bus.busy, 1'b0);
   endtask

   task automatic chk_all_zero(input string nm);
      chkb({nm, "_in_ready"}, bus.in_ready, 1'b0);
      chkb({nm, "_out_valid"}, bus.out_valid, 1'b0);
      chkb({nm, "_busy"}, bus.busy, 1'b0);
      chk({nm, "_ciphertext"}, bus.ciphertext, '0);
      chki({nm, "_dp_round"}, int'(bus.dp_round), 0);
      chk({nm, "_dp_state"}, bus.dp_state, '0);
      chk({nm, "_dp_key"}, bus.dp_key, '0);
   endtask

   int seq[$];

   initial begin
      for (int i = 0; i < 256; i++) sbox[i] = sb_calc(8'(i));
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.plaintext = '0;
      bus.key       = '0;
      bus.abort     = 1'b0;
      bus.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      chkb("release_in_ready_before_edge", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      chkb("release_in_ready_first_edge", bus.in_ready, 1'b1);

      // C.1 vector, consumer always ready
      issue(C1_PT, C1_K, C1_CT, 1'b1, 1'b0);
      wait_idle();

      // App.B vector while in_valid/plaintext/key churn through RUN
      issue(B_PT, B_K, B_CT, 1'b1, 1'b0);
      chk("run0_dp_state", bus.dp_state, B_PT);
      chk("run0_dp_key", bus.dp_key, B_K);
      seq.delete();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) break;
         seq.push_back(int'(bus.dp_round));
         bus.in_valid  = 1'($urandom_range(1));
         bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
         bus.key       = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.in_valid = 1'b0;
      chki("round_seq_len", seq.size(), 11);
      foreach (seq[i]) chki("round_seq", seq[i], i);
      wait_idle();

      // backpressure for 20 cycles
      bus.out_ready = 1'b0;
      issue(C1_PT, C1_K, C1_CT, 1'b1, 1'b0);
      wait_ov();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chkb("bp_hold", bus.out_valid && (bus.ciphertext === C1_CT) && !bus.in_ready, 1'b1);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.plaintext = B_PT;
      bus.key       = B_K;
      @(posedge clk); #1;
      chkb("bp_release_in_ready", bus.in_ready, 1'b1);
      chkb("bp_release_out_valid", bus.out_valid, 1'b0);
      chkb("bp_no_same_cycle_accept", bus.busy, 1'b0);
      bus.in_valid = 1'b0;

      // abort at round 5, then C.1 accepted with abort held in IDLE
      issue(C1_PT, C1_K, C1_CT, 1'b0, 1'b0);
      wait_round(5);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chkb("abort_run_busy", bus.busy, 1'b0);
      chkb("abort_run_in_ready", bus.in_ready, 1'b1);
      chkb("abort_run_out_valid", bus.out_valid, 1'b0);
      issue(C1_PT, C1_K, C1_CT, 1'b1, 1'b1);
      chkb("abort_idle_accept", bus.busy, 1'b1);
      wait_idle();

      // abort while DONE is stalled
      bus.out_ready = 1'b0;
      issue(B_PT, B_K, B_CT, 1'b1, 1'b0);
      wait_ov();
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chkb("abort_done_out_valid", bus.out_valid, 1'b0);
      chkb("abort_done_busy", bus.busy, 1'b0);
      bus.out_ready = 1'b1;

      // reset at round 7
      issue(B_PT, B_K, B_CT, 1'b0, 1'b0);
      wait_round(7);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("midrun_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chkb("midrun_release_before_edge", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      chkb("midrun_release_first_edge", bus.in_ready, 1'b1);

      issue(B_PT, B_K, B_CT, 1'b1, 1'b0);
      wait_idle();
      repeat (3) @(negedge clk);
      chki("scoreboard_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  a plaintext/key pair is offered.
REQ-005 in_ready  output  1  the block can accept a new block.
REQ-006 plaintext  input  [0:127]  block to encrypt; byte 0 is bits 0..7.
REQ-007 key  input  [0:127]  AES-128 cipher key.
REQ-008 abort  input  1  synchronous cancel of the current operation.
REQ-009 out_valid  output  1  ciphertext is valid.
REQ-010 out_ready  input  1  the consumer accepts the ciphertext.
REQ-011 ciphertext  output  [0:127]  encryption result.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 dp_round  output  [0:4]  round index driven to the round datapath, 0..10.
REQ-014 dp_state  output  [0:127]  state word driven to the datapath.
REQ-015 dp_key  output  [0:127]  previous round key driven to the datapath.
REQ-016 dp_out  input  [0:127]  datapath round result (combinational from dp_*).
REQ-017 dp_key_next  input  [0:127]  datapath round key for dp_round.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE; in_ready SHALL be high only in IDLE.
REQ-019 IDLE SHALL accept on in_valid&&in_ready: state_reg<=plaintext, key_reg<=key, rnd<=0, next state RUN.
REQ-020 In RUN, dp_round SHALL equal rnd, dp_state SHALL equal state_reg and dp_key SHALL equal key_reg.
REQ-021 Each RUN cycle SHALL capture state_reg<=dp_out; key_reg<=dp_key_next only when rnd is 1..10 (the round-0 key is retained).
REQ-022 In RUN, rnd SHALL increment by 1 per cycle; when rnd==10 the FSM SHALL go to DONE and rnd SHALL return to 0.
REQ-023 The datapath SHALL omit MixColumns when dp_round==10; the controller does not alter dp_out.
REQ-024 Latency: out_valid SHALL rise 11 cycles after the accept edge (11 RUN cycles for rounds 0..10).
REQ-025 In DONE, out_valid SHALL be 1 and ciphertext SHALL equal state_reg, held stable until out_ready.
REQ-026 On out_valid&&out_ready the FSM SHALL go to IDLE; no new block is accepted in that same cycle (minimum 13 cycles per block).
REQ-027 abort in RUN or DONE SHALL force IDLE on the next edge with out_valid low; abort SHALL have priority over out_ready and the round advance; abort in IDLE SHALL be ignored and SHALL NOT block a same-cycle accept.
REQ-028 Outside DONE, ciphertext SHALL read 0. Outside RUN, dp_round SHALL be 0 and dp_state/dp_key SHALL be 0.
REQ-029 in_valid during RUN or DONE SHALL be ignored; the plaintext and key inputs SHALL be sampled only at accept.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, rnd=0, state_reg=0 and key_reg=0.
REQ-031 During reset: in_ready=0, out_valid=0, busy=0, ciphertext=0, dp_*=0.
REQ-032 in_ready SHALL go high on the first clock edge after rst_n deasserts; an in-flight block is discarded.

Structure
REQ-033 A shared package aes_pkg SHALL hold BLOCK_W=128, NUM_ROUNDS=10, ROUND_W=5 and the FSM state enumeration.
REQ-034 The round datapath SHALL remain external; the block SHALL contain no sub-module. The test wrapper aes_core SHALL instantiate aes_round_ctrl together with the datapath.

Verification
REQ-035 Run the FIPS-197 C.1 vector: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 11 cycles after accept.
REQ-036 Run the FIPS-197 App.B vector: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> ciphertext 3925841d02dc09fbdc118597196a0b32.
REQ-037 Backpressure: hold out_ready=0 for 20 cycles -> out_valid and ciphertext stay stable, in_ready stays 0; on release, in_ready=1 one cycle later.
REQ-038 Abort: assert abort at rnd==5 -> IDLE next cycle with no out_valid; a following C.1 run still gives the correct result.
REQ-039 Reset mid-run: drop rst_n at rnd==7 -> all outputs 0 immediately; after release, in_ready rises on the first edge.
REQ-040 Ignored input: toggle in_valid and plaintext throughout RUN -> ciphertext unchanged; dp_round sequence is exactly 0,1,...,10.
